// File: rtl/sample_timer_pkg.sv
// Shared types and default parameters for the serial sample timer.
// Holds the FSM state encoding and default bit timing.
package sample_timer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    START_WAIT = 2'd1,
    SAMPLE     = 2'd2,
    DONE       = 2'd3
  } state_e;

  localparam int DEFAULT_BIT_PERIOD = 10;
  localparam int DEFAULT_NUM_BITS   = 9;

endpackage

// File: rtl/sample_timer_sync_counter.sv
// Up-counter with synchronous clear, enable and a programmable rollover value.
// rollover_o is combinational and high on the enabled cycle where count_o == max_i.
module sync_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] count_o,
  output logic             rollover_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign rollover_o = en_i && (count_q == max_i);
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i || rollover_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sample_timer.sv
// Mid-bit sample timer: strobes NUM_BITS times after a start edge, then pulses packet_done.
// Optional stop-bit check enabled by defining SAMPLE_TIMER_FRAMING_CHECK_EN.
module sample_timer
  import sample_timer_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
  parameter int NUM_BITS   = DEFAULT_NUM_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic start_detected,
  input  logic abort,
  input  logic serial_in,
  output logic shift_strobe,
  output logic packet_done,
  output logic busy
`ifdef SAMPLE_TIMER_FRAMING_CHECK_EN
  ,
  output logic framing_error
`endif
);

  localparam int FIRST_WAIT = BIT_PERIOD + BIT_PERIOD / 2;
  localparam int PW         = $clog2(FIRST_WAIT + 1);
  localparam int BW         = $clog2(NUM_BITS + 1);

  localparam logic [PW-1:0] FIRST_MAX = PW'(FIRST_WAIT - 1);
  localparam logic [PW-1:0] BIT_MAX   = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS);

  state_e state_q, state_d;
  logic   strobe_q, strobe_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;

  logic          enter_wait;
  logic          per_en, per_tick;
  logic [PW-1:0] per_max, per_cnt_unused;
  logic          bit_en, bit_roll_unused;
  logic [BW-1:0] bit_cnt;
  logic          all_sampled;

  assign enter_wait  = (state_q == IDLE) && start_detected && !abort;
  assign all_sampled = (bit_cnt == LAST_BIT);
  // The period counter idles once every bit is sampled so DONE follows the last strobe directly.
  assign per_en      = (state_q == START_WAIT) || ((state_q == SAMPLE) && !all_sampled);
  assign per_max     = (state_q == START_WAIT) ? FIRST_MAX : BIT_MAX;
  assign bit_en      = per_tick && !abort;

  sync_counter #(.WIDTH(PW)) u_period_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (enter_wait),
    .en_i       (per_en),
    .max_i      (per_max),
    .count_o    (per_cnt_unused),
    .rollover_o (per_tick)
  );

  sync_counter #(.WIDTH(BW)) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (enter_wait),
    .en_i       (bit_en),
    .max_i      (LAST_BIT),
    .count_o    (bit_cnt),
    .rollover_o (bit_roll_unused)
  );

  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_detected) state_d = START_WAIT;
      end
      START_WAIT: begin
        if (per_tick) begin
          state_d  = SAMPLE;
          strobe_d = 1'b1;
        end
      end
      SAMPLE: begin
        if (all_sampled) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (per_tick) begin
          strobe_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign shift_strobe = strobe_q;
  assign packet_done  = done_q;
  assign busy         = busy_q;

`ifdef SAMPLE_TIMER_FRAMING_CHECK_EN
  logic ferr_q, ferr_d;

  // The line is captured on the edge that ends the final strobe cycle.
  assign ferr_d = (state_q == SAMPLE) && all_sampled && !abort && !serial_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign framing_error = ferr_q;
`else
  logic serial_in_unused;
  assign serial_in_unused = serial_in;
`endif

endmodule
